// File: rtl/oai22_x2_stage.sv
// Vector OAI22 stage: ZN = ~((A1 | A2) & (B1 | B2)) per lane, with valid qualification.
// Define OAI22_X2_STAGE_REG_OUT_EN for a registered output (1-cycle latency); otherwise purely combinational.
module oai22_x2_stage #(
    parameter int unsigned      WIDTH  = 1,
    parameter logic [WIDTH-1:0] RST_ZN = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] B2,
    output logic [WIDTH-1:0] ZN,
    output logic             out_valid
);

    function automatic logic [WIDTH-1:0] oai22(
        input logic [WIDTH-1:0] a1,
        input logic [WIDTH-1:0] a2,
        input logic [WIDTH-1:0] b1,
        input logic [WIDTH-1:0] b2
    );
        return ~((a1 | a2) & (b1 | b2));
    endfunction

    logic [WIDTH-1:0] zn_d;

    assign zn_d = oai22(A1, A2, B1, B2);

`ifdef OAI22_X2_STAGE_REG_OUT_EN
    logic [WIDTH-1:0] zn_q;
    logic             vld_q;

    // ZN only loads on a valid beat, so idle-cycle input garbage never reaches the register
    always_ff @(posedge clk) begin
        if (rst) begin
            zn_q  <= RST_ZN;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                zn_q <= zn_d;
            end
        end
    end

    assign ZN        = zn_q;
    assign out_valid = vld_q;
`else
    // clk and RST_ZN have no role without the output register
    logic             unused_clk;
    logic [WIDTH-1:0] unused_rst_zn;

    assign unused_clk    = clk;
    assign unused_rst_zn = RST_ZN;

    assign ZN        = zn_d;
    assign out_valid = in_valid & ~rst;
`endif

endmodule

// File: tb/tb_oai22_x2_stage.sv
// Scoreboard bench for oai22_x2_stage (WIDTH=4); works for both the registered and combinational builds.
module tb_oai22_x2_stage;

    localparam int unsigned W      = 4;
    localparam logic [W-1:0] RST_V = 4'b1101;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A1, A2, B1, B2;
    logic [W-1:0] ZN;
    logic         out_valid;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];

    // Lane 0 truth table indexed by {A1,A2,B1,B2}: ZN=1 for codes 0,1,2,3,4,8,12
    localparam logic [15:0] TT = 16'b0001_0001_0001_1111;

    oai22_x2_stage #(.WIDTH(W), .RST_ZN(RST_V)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A1(A1), .A2(A2), .B1(B1), .B2(B2),
        .ZN(ZN), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a lane outputs 0 exactly when some A input and some B input are high
    function automatic logic [W-1:0] model(input logic [W-1:0] a1, input logic [W-1:0] a2,
                                           input logic [W-1:0] b1, input logic [W-1:0] b2);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) begin
            int na, nb;
            na = int'(a1[i]) + int'(a2[i]);
            nb = int'(b1[i]) + int'(b2[i]);
            r[i] = (na > 0 && nb > 0) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [W-1:0] a1, input logic [W-1:0] a2,
                         input logic [W-1:0] b1, input logic [W-1:0] b2, input logic [W-1:0] e);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; A1 = a1; A2 = a2; B1 = b1; B2 = b2;
        if (v && !r) exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, e);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: out_valid=1 with no result pending, ZN=%b", ZN);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (ZN !== e) begin
                    errors++;
                    $display("FAIL sb_zn: got %b expected %b", ZN, e);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] a1, a2, b1, b2, e;
        logic [3:0]   code;
        logic         r, v;

        rst = 1'b1; in_valid = 1'b0; A1 = '0; A2 = '0; B1 = '0; B2 = '0;

        drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
        @(negedge clk);
        chk("reset_valid", {3'b0, out_valid}, 4'b0);
`ifdef OAI22_X2_STAGE_REG_OUT_EN
        chk("reset_zn", ZN, RST_V);
`endif

        // Reset held with valid all-ones inputs
        drive(1'b1, 1'b1, '1, '1, '1, '1, 4'b0000);
        drive(1'b1, 1'b1, '1, '1, '1, '1, 4'b0000);
        @(negedge clk);
        chk("rst_ovr_valid", {3'b0, out_valid}, 4'b0);
`ifndef OAI22_X2_STAGE_REG_OUT_EN
        chk("rst_comb_zn", ZN, 4'b0000);
`endif
        drive(1'b0, 1'b1, '1, '1, '1, '1, 4'b0000);
        @(negedge clk);
`ifdef OAI22_X2_STAGE_REG_OUT_EN
        chk("rst_ovr_zn", ZN, RST_V);
        chk("rst_ovr_valid2", {3'b0, out_valid}, 4'b0);
`endif

        // Truth table on lane 0, random data on the other lanes
        for (int c = 0; c < 16; c++) begin
            code = 4'(c);
            a1 = {3'($urandom), code[3]};
            a2 = {3'($urandom), code[2]};
            b1 = {3'($urandom), code[1]};
            b2 = {3'($urandom), code[0]};
            e = model(a1, a2, b1, b2);
            e[0] = TT[c];
            drive(1'b0, 1'b1, a1, a2, b1, b2, e);
        end

        // Hold: a zero result must survive idle cycles with changing inputs
        drive(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) drive(1'b0, 1'b0, 'x, 'x, 'x, 'x, '0);
            else        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
            @(negedge clk);
`ifdef OAI22_X2_STAGE_REG_OUT_EN
            if (k >= 1) begin
                chk("hold_zn", ZN, 4'b0000);
                chk("hold_valid", {3'b0, out_valid}, 4'b0);
            end
`else
            chk("idle_valid", {3'b0, out_valid}, 4'b0);
`endif
        end

        // Independent lanes
        drive(1'b0, 1'b1, 4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b1110);

        // Mid-stream reset
        drive(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        drive(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
`ifndef OAI22_X2_STAGE_REG_OUT_EN
        @(negedge clk);
        chk("mid_rst_valid", {3'b0, out_valid}, 4'b0);
`endif
        drive(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
`ifdef OAI22_X2_STAGE_REG_OUT_EN
        @(negedge clk);
        chk("mid_rst_zn", ZN, RST_V);
        chk("mid_rst_valid", {3'b0, out_valid}, 4'b0);
`endif

        // Random traffic with sporadic resets
        for (int n = 0; n < 300; n++) begin
            r  = ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 3) != 0);
            a1 = 4'($urandom); a2 = 4'($urandom);
            b1 = 4'($urandom); b2 = 4'($urandom);
            drive(r, v, a1, a2, b1, b2, model(a1, a2, b1, b2));
        end

        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results never appeared, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
